playseq_ctrl: RTL

//  Game controller for PlaySeq. Sequences the 16x4 synchronous sequence RAM in rounds.

---
 rtl/playseq_ctrl_pkg.sv | 32 +++
 rtl/playseq_ctrl_if.sv | 26 ++
 rtl/playseq_ctrl_timer.sv | 21 ++
 rtl/playseq_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/playseq_ctrl_pkg.sv
// Shared types for the PlaySeq game controller: the state codes shown on the
// debug display and the last RAM address.
package playseq_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_PREP   = 4'd2,
        S_SHOW   = 4'd3,
        S_GAP    = 4'd4,
        S_WAIT   = 4'd5,
        S_CHECK  = 4'd6,
        S_REC    = 4'd7,
        S_REC_WR = 4'd8,
        S_NEXT   = 4'd9,
        S_WIN    = 4'd10,
        S_LOSE   = 4'd11,
        S_TOUT   = 4'd12
    } state_e;

    localparam logic [3:0] LAST_ADDR = 4'd15;

    // Width of a counter that must reach the largest of three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/playseq_ctrl_if.sv
// Board I/O and sequence-RAM signals of the PlaySeq controller.
interface playseq_ctrl_if;
    logic       start;
    logic       mode;
    logic [3:0] buttons;
    logic [3:0] ram_q;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_data;
    logic [3:0] leds;
    logic [3:0] round;
    logic       win;
    logic       lose;
    logic       tout;
    logic [3:0] db_state;

    modport master (
        input  start, mode, buttons, ram_q,
        output ram_addr, ram_we, ram_data, leds, round, win, lose, tout, db_state
    );

    modport slave (
        output start, mode, buttons, ram_q,
        input  ram_addr, ram_we, ram_data, leds, round, win, lose, tout, db_state
    );
endinterface

// File: rtl/playseq_ctrl_timer.sv
// Up-counter with synchronous clear/enable; done_o flags the terminal count.
module playseq_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + W'(1);
    end

    assign done_o = (cnt_q == last_i);
endmodule

// File: rtl/playseq_ctrl.sv
// PlaySeq game controller: replays notes 0..r from the sequence RAM each round,
// checks the player's presses against them and optionally records a new note.
module playseq_ctrl
    import playseq_ctrl_pkg::*;
#(
    parameter int SHOW_CYCLES    = 1000,
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic          clk,
    input  logic          reset,
    playseq_ctrl_if.master io
);
    localparam int TW = cnt_width(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

    state_e     state_q;
    logic [3:0] r_q, idx_q, press_q, btn_prev_q;
    logic       mode_q;

    // A held button counts once: only a rise from an all-released word is a press.
    logic press;
    assign press = (io.buttons != 4'd0) && (btn_prev_q == 4'd0);

    logic          rep_in, rep_done, tmo_in, tmo_done;
    logic [TW-1:0] rep_last;

    assign rep_in   = (state_q == S_SHOW) || (state_q == S_GAP);
    assign rep_last = (state_q == S_SHOW) ? TW'(SHOW_CYCLES - 1) : TW'(GAP_CYCLES - 1);
    assign tmo_in   = (state_q == S_WAIT) || (state_q == S_REC);

    playseq_ctrl_timer #(.W(TW)) u_rep_tmr (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (!rep_in || rep_done),
        .en_i   (rep_in && !rep_done),
        .last_i (rep_last),
        .done_o (rep_done)
    );

    playseq_ctrl_timer #(.W(TW)) u_tmo_tmr (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (!tmo_in),
        .en_i   (tmo_in),
        .last_i (TW'(TIMEOUT_CYCLES - 1)),
        .done_o (tmo_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            r_q        <= 4'd0;
            idx_q      <= 4'd0;
            mode_q     <= 1'b0;
            press_q    <= 4'd0;
            btn_prev_q <= 4'd0;
        end else begin
            btn_prev_q <= io.buttons;
            case (state_q)
                S_IDLE: if (io.start) state_q <= S_INIT;
                S_INIT: begin
                    r_q     <= 4'd0;
                    idx_q   <= 4'd0;
                    mode_q  <= io.mode;
                    state_q <= S_PREP;
                end
                S_PREP: state_q <= S_SHOW;
                S_SHOW: if (rep_done) state_q <= S_GAP;
                S_GAP: if (rep_done) begin
                    if (idx_q == r_q) begin
                        idx_q   <= 4'd0;
                        state_q <= S_WAIT;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= S_PREP;
                    end
                end
                S_WAIT: begin
                    if (press) begin
                        press_q <= io.buttons;
                        state_q <= S_CHECK;
                    end else if (tmo_done) begin
                        state_q <= S_TOUT;
                    end
                end
                // The RAM latched idx on the press edge, so ram_q is current here.
                S_CHECK: begin
                    if (press_q != io.ram_q)   state_q <= S_LOSE;
                    else if (idx_q != r_q) begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= S_WAIT;
                    end
                    else if (r_q == LAST_ADDR) state_q <= S_WIN;
                    else if (mode_q)           state_q <= S_REC;
                    else                       state_q <= S_NEXT;
                end
                S_REC: begin
                    if (press) begin
                        press_q <= io.buttons;
                        state_q <= S_REC_WR;
                    end else if (tmo_done) begin
                        state_q <= S_TOUT;
                    end
                end
                S_REC_WR: state_q <= S_NEXT;
                S_NEXT: begin
                    r_q     <= r_q + 4'd1;
                    idx_q   <= 4'd0;
                    state_q <= S_PREP;
                end
                S_WIN, S_LOSE, S_TOUT: if (io.start) state_q <= S_INIT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io.ram_addr = (state_q == S_REC_WR) ? r_q + 4'd1 : idx_q;
    assign io.ram_we   = (state_q == S_REC_WR);
    assign io.ram_data = press_q;
    assign io.leds     = (state_q == S_SHOW) ? io.ram_q : 4'd0;
    assign io.round    = r_q;
    assign io.win      = (state_q == S_WIN);
    assign io.lose     = (state_q == S_LOSE);
    assign io.tout     = (state_q == S_TOUT);
    assign io.db_state = state_q;
endmodule
